seven_seg_capture: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 24 ++
 rtl/seg_glyph_decode.sv | 35 +++
 rtl/seven_seg_capture.sv | 105 ++++++++++
 tb/tb_seven_seg_capture.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment capture path: active-low glyphs
// for hex digits 0..F and the number of multiplexed digits on the bus.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational inverse of the hex-to-seven-segment decoder: maps an
// active-low segment pattern back to its nibble and flags unknown glyphs.
module seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] segs,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (segs)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive-side monitor for the multiplexed 4-digit seven-segment bus:
// deglitches each anode/segs pair, decodes it and publishes whole frames.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  anode,
    input  logic [6:0]  segs,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        anode_err
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic [3:0]  anode_p0;
    logic [6:0]  segs_p0;
    logic [7:0]  cnt_p0;
    logic        vld_p1;

    logic [15:0] shadow;
    logic [3:0]  shadow_valid;
    logic [3:0]  mask;

    logic        same;
    logic [7:0]  cnt_next;
    logic [3:0]  anode_low;
    logic        one_hot;
    logic        multi_low;
    logic [3:0]  cap_sel;
    logic        publish;
    logic [3:0]  mask_next;
    logic        dec_legal;
    logic [3:0]  dec_nibble;

    seg_glyph_decode u_decode (
        .segs   (segs_p0),
        .legal  (dec_legal),
        .nibble (dec_nibble)
    );

    always_comb begin
        same      = ({anode, segs} == {anode_p0, segs_p0});
        cnt_next  = 8'd0;
        if (same) begin
            cnt_next = (cnt_p0 == STABLE_MAX) ? cnt_p0 : cnt_p0 + 8'd1;
        end

        anode_low = ~anode_p0;
        multi_low = ((anode_low & (anode_low - 4'd1)) != 4'd0);
        one_hot   = (anode_low != 4'd0) && !multi_low;
        cap_sel   = (vld_p1 && one_hot) ? anode_low : 4'd0;

        // A publish empties the mask; a capture in the same cycle still counts
        // toward the next frame.
        publish   = (mask == 4'hF);
        mask_next = (publish ? 4'd0 : mask) | cap_sel;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            anode_p0     <= 4'd0;
            segs_p0      <= 7'd0;
            cnt_p0       <= 8'd0;
            vld_p1       <= 1'b0;
            shadow       <= 16'd0;
            shadow_valid <= 4'd0;
            mask         <= 4'd0;
            digits       <= 16'd0;
            digit_valid  <= 4'd0;
            frame_done   <= 1'b0;
            anode_err    <= 1'b0;
        end else begin
            // p0: input sample and stability count
            anode_p0 <= anode;
            segs_p0  <= segs;
            cnt_p0   <= cnt_next;
            vld_p1   <= (cnt_next == STABLE_MAX) && (cnt_p0 != STABLE_MAX);

            // p1: capture the stable sample into the shadow frame
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_sel[i]) begin
                    shadow[4*i +: 4] <= dec_nibble;
                    shadow_valid[i]  <= dec_legal;
                end
            end
            if (vld_p1 && multi_low) begin
                anode_err <= 1'b1;
            end
            mask <= mask_next;

            // p2: publish the completed frame atomically
            frame_done <= publish;
            if (publish) begin
                digits      <= shadow;
                digit_valid <= shadow_valid;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: directed scan sequences push
// expected frames; a monitor pops and compares on every frame_done.
module tb_seven_seg_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  anode;
    logic [6:0]  segs;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        anode_err;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  v;
    } frame_t;

    frame_t      exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          frames = 0;
    int          stab_viol = 0;
    logic        fd_prev = 1'b0;
    logic [15:0] last_d = 16'd0;
    logic [3:0]  last_v = 4'd0;
    int          f0;

    seven_seg_capture #(.STABLE_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .anode       (anode),
        .segs        (segs),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .anode_err   (anode_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        anode = a;
        segs  = s;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_digit(input int i, input logic [6:0] s);
        logic [3:0] a;
        a = 4'b1111;
        a[i] = 1'b0;
        drive(a, s, 10);
    endtask

    task automatic blank();
        drive(4'b1111, 7'h7F, 5);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare published frames and guard against stray output changes
    always @(negedge clock) begin
        if (reset) begin
            last_d = 16'd0;
            last_v = 4'd0;
        end else if (frame_done) begin
            frames++;
            check("frame_done_width", {31'd0, fd_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got digits=%h valid=%h expected no frame", digits, digit_valid);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                check("frame_digits", {16'd0, digits}, {16'd0, e.d});
                check("frame_valid", {28'd0, digit_valid}, {28'd0, e.v});
            end
            last_d = digits;
            last_v = digit_valid;
        end else if (digits !== last_d || digit_valid !== last_v) begin
            stab_viol++;
            last_d = digits;
            last_v = digit_valid;
        end
        fd_prev = frame_done;
    end

    initial begin
        reset = 1'b1;
        anode = 4'b1111;
        segs  = 7'h7F;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_digits", {16'd0, digits}, 32'd0);
        check("reset_valid", {28'd0, digit_valid}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        check("reset_anode_err", {31'd0, anode_err}, 32'd0);
        blank();

        // Basic frame, scan order 3..0
        exp_q.push_back('{d: 16'h4510, v: 4'hF});
        send_digit(3, 7'h19);
        send_digit(2, 7'h12);
        send_digit(1, 7'h79);
        send_digit(0, 7'h40);
        blank();
        check("frames_after_t1", frames, 1);

        // Short glitch on digit 0 must not be captured
        exp_q.push_back('{d: 16'h1243, v: 4'hF});
        drive(4'b1110, 7'h24, 3);
        drive(4'b1110, 7'h30, 10);
        send_digit(1, 7'h19);
        send_digit(2, 7'h24);
        send_digit(3, 7'h79);
        blank();
        check("frames_after_t2", frames, 2);

        // Illegal glyph on digit 2
        exp_q.push_back('{d: 16'h3067, v: 4'b1011});
        send_digit(3, 7'h30);
        send_digit(2, 7'h7F);
        send_digit(1, 7'h02);
        send_digit(0, 7'h78);
        blank();
        check("frames_after_t3", frames, 3);
        check("no_err_on_illegal", {31'd0, anode_err}, 32'd0);

        // Multiple anodes low: sticky error, mask untouched
        drive(4'b1100, 7'h40, 10);
        check("anode_err_set", {31'd0, anode_err}, 32'd1);
        blank();
        exp_q.push_back('{d: 16'h89AB, v: 4'hF});
        send_digit(3, 7'h00);
        send_digit(2, 7'h10);
        blank();
        check("no_early_publish", frames, 3);
        send_digit(1, 7'h08);
        send_digit(0, 7'h03);
        blank();
        check("frames_after_t4", frames, 4);
        check("anode_err_sticky", {31'd0, anode_err}, 32'd1);
        pulse_reset();
        check("err_cleared", {31'd0, anode_err}, 32'd0);
        check("digits_cleared", {16'd0, digits}, 32'd0);
        check("valid_cleared", {28'd0, digit_valid}, 32'd0);

        // Reset mid-frame discards partial captures
        blank();
        send_digit(0, 7'h06);
        send_digit(1, 7'h0E);
        pulse_reset();
        f0 = frames;
        exp_q.push_back('{d: 16'hDCBA, v: 4'hF});
        send_digit(3, 7'h21);
        send_digit(2, 7'h46);
        send_digit(1, 7'h03);
        send_digit(0, 7'h08);
        blank();
        check("one_frame_after_reset", frames - f0, 1);
        check("digits_after_reset", {16'd0, digits}, 32'h0000DCBA);

        // Ascending scan order
        exp_q.push_back('{d: 16'hEFC1, v: 4'hF});
        send_digit(0, 7'h79);
        send_digit(1, 7'h46);
        send_digit(2, 7'h0E);
        send_digit(3, 7'h06);
        blank();
        check("frames_after_t6", frames, 6);

        check("queue_empty", exp_q.size(), 0);
        check("outputs_stable", stab_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
